micro_trace_rec: RTL and testbench

// Response recorder for the 4-bit microprocessor bench; it is the writer side of the stimulus vector format.
// - Captures one entry per clock from the live processor signals: accum, data_in and reset.
// - Packs each entry into the 12-bit vector layout used by the stimulus ROM.
// - Replays the stored vectors in order over a valid/ready port, so a recorded run becomes a stimulus table.

---
 rtl/micro_trace_rec.sv | 145 ++++++++++++++
 tb/tb_micro_trace_rec.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_trace_rec.sv
// Response recorder: captures accum/data_in/reset once per clock into packed
// 12-bit stimulus vectors, then replays them in order over a valid/ready port.
module micro_trace_rec #(
    parameter int DEPTH = 32,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [3:0]    cap_accum_i,
    input  logic [3:0]    cap_data_in_i,
    input  logic          cap_reset_i,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [11:0]   rd_data_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [AW:0]   count_o,
    output logic          busy_o,
    output logic          full_o
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          rd_valid_q, rd_valid_d;
    logic [11:0]   rd_data_q, rd_data_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    logic [11:0]   mem_q [DEPTH];
    logic          mem_we;
    logic [11:0]   mem_wdata;
    logic          last;
    logic          at_end;

    assign at_end = (wr_ptr_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        full_d     = full_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_addr_d  = rd_addr_q;
        mem_we     = 1'b0;
        last       = 1'b0;
        mem_wdata  = 12'h000;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    full_d   = 1'b0;
                end
            end
            CAPTURE: begin
                last      = stop_i | at_end;
                mem_we    = reset_i;
                mem_wdata = {cap_accum_i, last, 2'b00, cap_reset_i, cap_data_in_i};
                count_d   = count_q + CNT_ONE;
                if (last) begin
                    state_d  = DRAIN;
                    rd_ptr_d = '0;
                    full_d   = at_end & ~stop_i;
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
            end
            DRAIN: begin
                // rd_valid low in DRAIN only on the setup edge; the done bit of the
                // presented vector decides whether a transfer ends the replay
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_q[rd_ptr_q[IW-1:0]];
                    rd_addr_d  = rd_ptr_q;
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                end else if (rd_ready_i) begin
                    if (rd_data_q[7]) begin
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        rd_data_d = mem_q[rd_ptr_q[IW-1:0]];
                        rd_addr_d = rd_ptr_q;
                        rd_ptr_d  = rd_ptr_q + PTR_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto plain RAM
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[IW-1:0]] <= mem_wdata;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_addr_o  = rd_addr_q;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_micro_trace_rec.sv
// Scoreboard bench for micro_trace_rec: expected vectors are queued as each entry
// is captured and a negedge monitor pops them as the replay port hands them over.
module tb_micro_trace_rec;

    localparam int DEPTH = 32;
    localparam int AW    = 6;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [3:0]    cap_accum_i = 4'h0;
    logic [3:0]    cap_data_in_i = 4'h0;
    logic          cap_reset_i = 1'b0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [11:0]   rd_data_o;
    logic [AW-1:0] rd_addr_o;
    logic [AW:0]   count_o;
    logic          busy_o;
    logic          full_o;

    typedef struct {
        int addr;
        int data;
    } expEntry_t;

    expEntry_t  expQ[$];
    int         testCount = 0;
    int         failCount = 0;
    logic [3:0] stimAccum [DEPTH];
    logic [3:0] stimData  [DEPTH];
    logic       stimRst   [DEPTH];
    bit         readyPattern [4];
    bit         holdPending = 1'b0;
    logic [11:0] heldData;
    logic [AW-1:0] heldAddr;

    micro_trace_rec #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .cap_accum_i  (cap_accum_i),
        .cap_data_in_i(cap_data_in_i),
        .cap_reset_i  (cap_reset_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_addr_o    (rd_addr_o),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .full_o       (full_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a capture keeps entries up to and including the stop cycle,
    // capped at DEPTH; the flag is set only when the cap ended it without a stop.
    function automatic int entriesFor(input int stopIdx);
        if (stopIdx >= 0 && stopIdx < DEPTH) return stopIdx + 1;
        return DEPTH;
    endfunction

    function automatic int fullFor(input int stopIdx);
        return (stopIdx >= 0 && stopIdx < DEPTH) ? 0 : 1;
    endfunction

    function automatic int vectorFor(input int i, input int n);
        return int'(stimAccum[i]) * 256 + ((i == n - 1) ? 128 : 0)
             + int'(stimRst[i]) * 16 + int'(stimData[i]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk_i) begin
        if (holdPending) begin
            checkOutput("stall_valid", 32'(rd_valid_o), 32'd1);
            checkOutput("stall_data", 32'(rd_data_o), 32'(heldData));
            checkOutput("stall_addr", 32'(rd_addr_o), 32'(heldAddr));
        end
        holdPending = (reset_i === 1'b1) && (rd_valid_o === 1'b1) && (rd_ready_i === 1'b0);
        heldData    = rd_data_o;
        heldAddr    = rd_addr_o;
        if (reset_i === 1'b1 && rd_valid_o === 1'b1 && rd_ready_i === 1'b1) begin
            if (expQ.size() == 0) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL unexpected_vector: got addr %0d data 0x%0h, expected none",
                         rd_addr_o, rd_data_o);
            end else begin
                expEntry_t e;
                e = expQ.pop_front();
                checkOutput("vec_addr", 32'(rd_addr_o), 32'(e.addr));
                checkOutput("vec_data", 32'(rd_data_o), 32'(e.data));
            end
        end
    end

    task automatic fillRandom();
        for (int i = 0; i < DEPTH; i++) begin
            stimAccum[i] = 4'($urandom_range(0, 15));
            stimData[i]  = 4'($urandom_range(0, 15));
            stimRst[i]   = 1'($urandom_range(0, 1));
        end
    endtask

    // One full session: start, capture, then drain with the chosen ready behaviour
    // (0: always ready, 1: repeating 1,0,0,1, other: random).
    task automatic applyStimulus(input int stopIdx, input int readyMode, input bit pulseStart);
        int n;
        int cycles;
        expEntry_t e;
        n = entriesFor(stopIdx);
        @(posedge clk_i); #1;
        start_i    = 1'b1;
        stop_i     = 1'b1;
        rd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        checkOutput("busy_after_start", 32'(busy_o), 32'd1);
        checkOutput("count_cleared", 32'(count_o), 32'd0);
        checkOutput("full_cleared", 32'(full_o), 32'd0);
        for (int i = 0; i < n; i++) begin
            cap_accum_i   = stimAccum[i];
            cap_data_in_i = stimData[i];
            cap_reset_i   = stimRst[i];
            stop_i        = (i == stopIdx);
            start_i       = pulseStart ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_ready_i    = 1'($urandom_range(0, 1));
            e.addr = i;
            e.data = vectorFor(i, n);
            expQ.push_back(e);
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        stop_i  = 1'b0;
        checkOutput("count_after_capture", 32'(count_o), 32'(n));
        checkOutput("full_after_capture", 32'(full_o), 32'(fullFor(stopIdx)));
        checkOutput("busy_in_drain", 32'(busy_o), 32'd1);
        checkOutput("valid_delayed", 32'(rd_valid_o), 32'd0);
        cycles = 0;
        while (busy_o === 1'b1 && cycles < 8 * DEPTH + 16) begin
            case (readyMode)
                0:       rd_ready_i = 1'b1;
                1:       rd_ready_i = readyPattern[cycles % 4];
                default: rd_ready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (pulseStart) start_i = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
            cycles++;
        end
        start_i    = 1'b0;
        rd_ready_i = 1'b0;
        checkOutput("drain_finished", 32'(busy_o), 32'd0);
        if (readyMode == 0) checkOutput("drain_cycles", 32'(cycles), 32'(n + 1));
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("valid_low_after", 32'(rd_valid_o), 32'd0);
        checkOutput("count_hold", 32'(count_o), 32'(n));
        checkOutput("full_hold", 32'(full_o), 32'(fullFor(stopIdx)));
        expQ.delete();
    endtask

    initial begin
        readyPattern[0] = 1'b1;
        readyPattern[1] = 1'b0;
        readyPattern[2] = 1'b0;
        readyPattern[3] = 1'b1;

        // Reset must win over start and ready
        reset_i    = 1'b0;
        start_i    = 1'b1;
        rd_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_valid", 32'(rd_valid_o), 32'd0);
        checkOutput("rst_data", 32'(rd_data_o), 32'd0);
        checkOutput("rst_addr", 32'(rd_addr_o), 32'd0);
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_full", 32'(full_o), 32'd0);
        reset_i    = 1'b1;
        start_i    = 1'b0;
        rd_ready_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("idle_after_rst", 32'(busy_o), 32'd0);

        // Reset in the middle of a capture
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("midcap_count", 32'(count_o), 32'd3);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("midcap_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("midcap_rst_count", 32'(count_o), 32'd0);
        reset_i = 1'b1;

        // Four entries, stop on the fourth
        for (int i = 0; i < DEPTH; i++) begin
            stimAccum[i] = 4'(i + 1);
            stimData[i]  = 4'hA;
            stimRst[i]   = 1'b0;
        end
        applyStimulus(3, 0, 1'b0);

        fillRandom();
        applyStimulus(-1, 0, 1'b0);
        fillRandom();
        applyStimulus(9, 1, 1'b0);
        fillRandom();
        applyStimulus(DEPTH - 1, 2, 1'b1);

        // Processor reset marked on the first entry only
        fillRandom();
        for (int i = 0; i < DEPTH; i++) stimRst[i] = (i == 0);
        applyStimulus(1, 0, 1'b0);

        fillRandom();
        applyStimulus(0, 2, 1'b0);
        for (int s = 0; s < 6; s++) begin
            int stopIdx;
            fillRandom();
            stopIdx = $urandom_range(0, DEPTH + 8);
            if (stopIdx >= DEPTH) stopIdx = -1;
            applyStimulus(stopIdx, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
